oddeven_sorter: RTL
===================

// Module: oddeven_sorter
// PURPOSE
//  Word-parallel odd-even transposition sorter; next generation of the bit-serial bubble sort array.
//  Holds K_NUMBERS words of N_BITS, sorts in place with one compare/swap phase per clock.
//  Adds ascending/descending and signed/unsigned modes, early termination, a phase count and a clearable sticky IRQ.
//  Sits behind the same host register file: parallel per-word load, full-array readback.
// PARAMETERS
//  N_BITS     8   width of each word
//  K_NUMBERS  16  number of words held, >=2
//  SIGNED     0   1: compare as two's complement; 0: unsigned
// PORTS
//  clk          in   1                  clock, all logic on rising edge
//  rst          in   1                  synchronous active-high reset
//  load_i       in   K_NUMBERS          per-word write enable; honoured only when not busy_o
//  writedata_i  in   K_NUMBERS*N_BITS   word i at bits [(i+1)*N_BITS-1 : i*N_BITS]
//  readdata_o   out  K_NUMBERS*N_BITS   registered array contents, same packing
//  descending_i in   1                  0: word 0 smallest; 1: word 0 largest; sampled with start_i
//  start_i      in   1                  begin sort; ignored while busy_o
//  abort_i      in   1                  stop sort, return to IDLE
//  irq_clear_i  in   1                  clears interrupt_o
//  busy_o       out  1                  high in SORT
//  done_o       out  1                  high in DONE
//  interrupt_o  out  1                  sticky completion flag
//  pass_cnt_o   out  $clog2(K_NUMBERS+1) phases executed by last/current sort
// BEHAVIOUR
//  Reset: all words 0, state IDLE, busy_o=0, done_o=0, interrupt_o=0, pass_cnt_o=0, mode latch=0.
//  FSM IDLE/SORT/DONE. IDLE|DONE + start_i & !abort_i -> SORT; latch descending_i; pass_cnt_o<=0; phase parity<=even.
//  SORT: each cycle one phase. Even phase compares pairs (0,1),(2,3)..; odd phase pairs (1,2),(3,4)..
//  Pair (j,j+1) swaps iff asc: w[j]>w[j+1]; desc: w[j]<w[j+1]. Equal words never swap (stable).
//  Each phase: pass_cnt_o+=1, parity toggles, per-phase swap flag = OR of all pair swaps.
//  Terminate at the edge executing phase p when (p>=2 and phases p-1,p both had no swap) or p==K_NUMBERS;
//  that edge writes the phase result and moves SORT->DONE; done_o high, interrupt_o set from next cycle.
//  Latency: start sampled at edge E0, phases at E1..Ep; done_o=1 after Ep; worst case p=K_NUMBERS.
//  DONE: done_o held until start_i (-> SORT) or any load_i bit (-> IDLE, load applied same edge).
//  abort_i in SORT: -> IDLE at that edge, no phase applied that edge, words keep partial order,
//   pass_cnt_o frozen, interrupt_o not set. abort_i in IDLE/DONE: -> IDLE, no other effect.
//  start_i and abort_i same cycle: abort wins. start_i with load_i in IDLE/DONE: load applied, then sort begins next edge.
//  load_i while busy_o: ignored, contents unaffected by host.
//  interrupt_o: set on SORT->DONE; cleared by irq_clear_i or accepted start; set beats clear on same edge.
//  Compare is N_BITS wide, no widening; SIGNED selects signed compare of the same bits.
//  Odd K_NUMBERS: last word unpaired in even phases, first word unpaired in odd phases.
// TESTING
//  K=4 asc, load [4,3,2,1] (w0..w3), start -> E1 [3,4,1,2], E2 [3,1,4,2], E3 [1,3,2,4], E4 [1,2,3,4]; done_o after E4, pass_cnt_o=4, interrupt_o=1.
//  K=4 asc, load [1,2,3,4], start -> no swaps, done_o after E2, pass_cnt_o=2, data unchanged.
//  K=4 desc, load [1,2,2,5] -> [5,2,2,1]; SIGNED=1 asc load [8'hFF,8'h01,8'h80,8'h00] -> [80,FF,00,01].
//  K=4 asc [4,3,2,1], abort_i at E2 -> IDLE, readdata [3,4,1,2], pass_cnt_o=1, done_o=0, interrupt_o=0.
//  load_i=4'hF during SORT ignored; start_i during SORT ignored; start+abort in IDLE -> stays IDLE.
//  irq_clear_i on completion edge -> interrupt_o=1; next cycle irq_clear_i -> 0; rst mid-SORT -> all words 0, IDLE.

Source files
------------

// File: rtl/oddeven_sorter.sv
// -----------------------------------------------------------------------------
// oddeven_sorter
//   Word-parallel odd-even transposition sorter. Holds K_NUMBERS words of
//   N_BITS and sorts them in place, one compare/swap phase per clock.
//   Supports ascending/descending order (latched at start), signed or unsigned
//   comparison, early termination after two consecutive swap-free phases,
//   a phase counter and a sticky, clearable completion interrupt.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   load_i        per-word write enable (ignored while busy_o)
//   writedata_i   packed write data, word i at [(i+1)*N_BITS-1 : i*N_BITS]
//   readdata_o    registered array contents, same packing
//   descending_i  sort order, sampled together with an accepted start_i
//   start_i       begin a sort (ignored while busy_o)
//   abort_i       stop any sort and return to IDLE (wins over start_i)
//   irq_clear_i   clears interrupt_o (a completion on the same edge wins)
//   busy_o        high while sorting
//   done_o        high after a sort completed, until start or load
//   interrupt_o   sticky completion flag
//   pass_cnt_o    number of phases executed by the last/current sort
// -----------------------------------------------------------------------------
module oddeven_sorter #(
  parameter int N_BITS    = 8,
  parameter int K_NUMBERS = 16,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [K_NUMBERS-1:0]            load_i,
  input  logic [K_NUMBERS*N_BITS-1:0]     writedata_i,
  output logic [K_NUMBERS*N_BITS-1:0]     readdata_o,
  input  logic                            descending_i,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic                            irq_clear_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            interrupt_o,
  output logic [$clog2(K_NUMBERS+1)-1:0]  pass_cnt_o
);

  localparam int CW = $clog2(K_NUMBERS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [K_NUMBERS-1:0][N_BITS-1:0] word_reg;
  logic [K_NUMBERS-1:0][N_BITS-1:0] word_phase;
  logic [K_NUMBERS-2:0]             pair_swap;

  logic          desc_reg;
  logic          parity_reg;     // 0: even phase (pairs 0-1, 2-3 ..), 1: odd phase
  logic          prev_swap_reg;  // swap flag of the previous phase
  logic [CW-1:0] pass_cnt_reg;
  logic          irq_reg;

  logic          any_swap;
  logic [CW-1:0] pass_inc;
  logic          phase_last;
  logic          start_accept;
  logic          sort_step;

  // ---------------------------------------------------------------------------
  // Compare network: one comparator per adjacent pair; only pairs matching the
  // current phase parity are allowed to swap, so active pairs never overlap.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < K_NUMBERS - 1; gi++) begin : g_pair
      logic a_gt_b;
      logic b_gt_a;
      if (SIGNED) begin : g_signed
        assign a_gt_b = $signed(word_reg[gi]) > $signed(word_reg[gi+1]);
        assign b_gt_a = $signed(word_reg[gi+1]) > $signed(word_reg[gi]);
      end else begin : g_unsigned
        assign a_gt_b = word_reg[gi] > word_reg[gi+1];
        assign b_gt_a = word_reg[gi+1] > word_reg[gi];
      end
      // Strict compares: equal words never swap, keeping the sort stable.
      assign pair_swap[gi] = (parity_reg == 1'(gi % 2)) &&
                             (desc_reg ? b_gt_a : a_gt_b);
    end
  endgenerate

  // Each word takes its right neighbour if its own pair (gi,gi+1) swaps, or its
  // left neighbour if pair (gi-1,gi) swaps; edge words have only one neighbour.
  generate
    for (genvar gi = 0; gi < K_NUMBERS; gi++) begin : g_word
      logic              from_right;
      logic              from_left;
      logic [N_BITS-1:0] right_val;
      logic [N_BITS-1:0] left_val;
      if (gi < K_NUMBERS - 1) begin : g_r
        assign from_right = pair_swap[gi];
        assign right_val  = word_reg[gi+1];
      end else begin : g_r_none
        assign from_right = 1'b0;
        assign right_val  = word_reg[gi];
      end
      if (gi > 0) begin : g_l
        assign from_left = pair_swap[gi-1];
        assign left_val  = word_reg[gi-1];
      end else begin : g_l_none
        assign from_left = 1'b0;
        assign left_val  = word_reg[gi];
      end
      assign word_phase[gi] = from_right ? right_val :
                              from_left  ? left_val  : word_reg[gi];
    end
  endgenerate

  assign any_swap = |pair_swap;
  assign pass_inc = pass_cnt_reg + CW'(1);

  // Stop after two consecutive swap-free phases, or after K phases which is
  // the guaranteed worst case for odd-even transposition.
  assign phase_last = ((pass_inc >= CW'(2)) && !any_swap && !prev_swap_reg) ||
                      (pass_inc == CW'(K_NUMBERS));

  assign start_accept = (state_reg != ST_SORT) && start_i && !abort_i;
  assign sort_step    = (state_reg == ST_SORT) && !abort_i;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_i && !abort_i) state_next = ST_SORT;
      end
      ST_SORT: begin
        if (abort_i)         state_next = ST_IDLE;
        else if (phase_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (abort_i)        state_next = ST_IDLE;
        else if (start_i)   state_next = ST_SORT;
        else if (|load_i)   state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_reg)
      ST_SORT: busy_o = 1'b1;
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word storage: host loads when not sorting, phase results while sorting.
  // A load that coincides with an accepted start lands before the first phase.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg <= '0;
    end else if (state_reg == ST_SORT) begin
      if (!abort_i) word_reg <= word_phase;
    end else begin
      for (int i = 0; i < K_NUMBERS; i++) begin
        if (load_i[i]) word_reg[i] <= writedata_i[i*N_BITS +: N_BITS];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sort control registers and interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      desc_reg      <= 1'b0;
      parity_reg    <= 1'b0;
      prev_swap_reg <= 1'b0;
      pass_cnt_reg  <= '0;
      irq_reg       <= 1'b0;
    end else begin
      if (start_accept) begin
        desc_reg      <= descending_i;
        parity_reg    <= 1'b0;
        prev_swap_reg <= 1'b0;
        pass_cnt_reg  <= '0;
      end else if (sort_step) begin
        parity_reg    <= ~parity_reg;
        prev_swap_reg <= any_swap;
        pass_cnt_reg  <= pass_inc;
      end

      // Completion beats a clear arriving on the same edge.
      if (sort_step && phase_last) begin
        irq_reg <= 1'b1;
      end else if (irq_clear_i || start_accept) begin
        irq_reg <= 1'b0;
      end
    end
  end

  assign readdata_o  = word_reg;
  assign interrupt_o = irq_reg;
  assign pass_cnt_o  = pass_cnt_reg;

endmodule
